// File: rtl/regfile_pkg.sv
// Shared sizes and requester encodings for the register-file read arbiter.
package regfile_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    localparam logic [NUM_REQ-1:0] REQ0_OH = 3'b001;
    localparam logic [NUM_REQ-1:0] REQ1_OH = 3'b010;
    localparam logic [NUM_REQ-1:0] REQ2_OH = 3'b100;

    typedef logic [1:0] req_idx_t;

    // Last starts at requester 2 so requester 0 wins the first arbitration.
    localparam req_idx_t LAST_RESET = 2'd2;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin selector: the requester just after 'last' has top priority.
module rr_arbiter3
    import regfile_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (last)
            2'd0: begin
                if      (req[1]) gnt = REQ1_OH;
                else if (req[2]) gnt = REQ2_OH;
                else if (req[0]) gnt = REQ0_OH;
            end
            2'd1: begin
                if      (req[2]) gnt = REQ2_OH;
                else if (req[0]) gnt = REQ0_OH;
                else if (req[1]) gnt = REQ1_OH;
            end
            default: begin
                if      (req[0]) gnt = REQ0_OH;
                else if (req[1]) gnt = REQ1_OH;
                else if (req[2]) gnt = REQ2_OH;
            end
        endcase
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates three read requesters onto one registered register-file read mux,
// with a grant stage, a response stage and forwarding of same-cycle writes.
module regfile_read_arbiter
    import regfile_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [ADDR_W-1:0]  Addr0,
    input  logic [ADDR_W-1:0]  Addr1,
    input  logic [ADDR_W-1:0]  Addr2,
    input  logic               Hold,
    input  logic               WrEn,
    input  logic [ADDR_W-1:0]  WrAdd,
    input  logic [DATA_W-1:0]  WrData,
    output logic [ADDR_W-1:0]  ReadAdd,
    input  logic [DATA_W-1:0]  MuxData,
    output logic [NUM_REQ-1:0] Gnt,
    output logic [NUM_REQ-1:0] RdValid,
    output logic [DATA_W-1:0]  RdData
);

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]  read_add_q, read_add_d;
    logic               byp_flag_q, byp_flag_d;
    logic [DATA_W-1:0]  byp_data_q, byp_data_d;
    req_idx_t           last_q, last_d;

    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               fwd_hit;

    // A request still high while its grant is out is not granted again at this edge.
    assign req_elig = Req & ~gnt_q;

    rr_arbiter3 u_rr (
        .req  (req_elig),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        gnt_d      = Hold ? '0 : arb_gnt;
        read_add_d = read_add_q;
        last_d     = last_q;
        if (gnt_d == REQ0_OH) begin
            read_add_d = Addr0;
            last_d     = 2'd0;
        end else if (gnt_d == REQ1_OH) begin
            read_add_d = Addr1;
            last_d     = 2'd1;
        end else if (gnt_d == REQ2_OH) begin
            read_add_d = Addr2;
            last_d     = 2'd2;
        end

        rd_valid_d = gnt_q;

        // The mux samples ReadAdd at this edge, so a write landing now would be missed.
        fwd_hit    = (|gnt_q) && WrEn && (WrAdd == read_add_q) && (WrAdd != '0);
        byp_flag_d = fwd_hit;
        byp_data_d = fwd_hit ? WrData : byp_data_q;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            gnt_q      <= '0;
            rd_valid_q <= '0;
            read_add_q <= '0;
            byp_flag_q <= 1'b0;
            byp_data_q <= '0;
            last_q     <= LAST_RESET;
        end else begin
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            read_add_q <= read_add_d;
            byp_flag_q <= byp_flag_d;
            byp_data_q <= byp_data_d;
            last_q     <= last_d;
        end
    end

    assign Gnt     = gnt_q;
    assign RdValid = rd_valid_q;
    assign ReadAdd = read_add_q;
    assign RdData  = byp_flag_q ? byp_data_q : MuxData;

endmodule
